// File: rtl/soc_system_pcp_0_cpu_0_oci_dct_pkg.sv
// Shared constants and state encoding for the OCI compressed-trace buffer sequencer.
package soc_system_pcp_0_cpu_0_oci_dct_pkg;

   localparam int unsigned DCT_SYM_W         = 2;
   localparam int unsigned DCT_SLOTS         = 15;
   localparam int unsigned DCT_WORD_W        = DCT_SYM_W * DCT_SLOTS;
   localparam int unsigned DCT_CNT_W         = 4;
   localparam int unsigned DCT_FLUSH_TIMEOUT = 64;

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_ENDED = 2'd2
   } dct_state_e;

endpackage

// File: rtl/soc_system_pcp_0_cpu_0_oci_dct_timer.sv
// Idle counter: counts enabled cycles and saturates at TIMEOUT-1, where expire_o holds
// until the owner clears it, so a flush blocked by backpressure is not lost.
module soc_system_pcp_0_cpu_0_oci_dct_timer #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: clear wins, otherwise count up to the saturation point
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != LAST)) begin
         cnt_d = cnt_q + W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/soc_system_pcp_0_cpu_0_oci_dct_ctrl.sv
// DCT buffer sequencer: packs 2-bit trace symbols into 15-slot words, hands them to the
// trace FIFO over valid/ready, flushes partial words on idle timeout and on end-of-test drain.
module soc_system_pcp_0_cpu_0_oci_dct_ctrl
   import soc_system_pcp_0_cpu_0_oci_dct_pkg::*;
#(
   parameter int unsigned SYM_W         = DCT_SYM_W,
   parameter int unsigned SLOTS         = DCT_SLOTS,
   parameter int unsigned FLUSH_TIMEOUT = DCT_FLUSH_TIMEOUT
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     sym_valid,
   input  logic [SYM_W-1:0]         sym,
   output logic                     sym_ready,
   output logic                     word_valid,
   output logic [SYM_W*SLOTS-1:0]   word_data,
   output logic [DCT_CNT_W-1:0]     word_count,
   input  logic                     word_ready,
   input  logic                     test_ending,
   output logic [SYM_W*SLOTS-1:0]   dct_buffer,
   output logic [DCT_CNT_W-1:0]     dct_count,
   output logic                     test_has_ended
);

   localparam int unsigned WORD_W = SYM_W * SLOTS;
   localparam int unsigned CNT_W  = DCT_CNT_W;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(SLOTS);

   dct_state_e         state_q, state_d;
   logic [WORD_W-1:0]  buf_q, buf_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               wvalid_q, wvalid_d;
   logic [WORD_W-1:0]  wdata_q, wdata_d;
   logic [CNT_W-1:0]   wcount_q, wcount_d;
   logic               ended_q, ended_d;

   logic out_free;
   logic accept;
   logic xfer;
   logic buf_busy;
   logic tmr_expire;

   assign out_free  = !wvalid_q || word_ready;
   assign buf_busy  = (cnt_q != {CNT_W{1'b0}});
   assign sym_ready = (state_q == ST_FILL) && ((cnt_q < FULL) || out_free);
   assign accept    = sym_valid && sym_ready;

   // An accepted symbol always resets idleness, so the timeout cannot fire on that edge
   assign xfer = out_free && buf_busy &&
                 ((cnt_q == FULL) || (state_q == ST_DRAIN) || (tmr_expire && !accept));

   soc_system_pcp_0_cpu_0_oci_dct_timer #(
      .TIMEOUT (FLUSH_TIMEOUT)
   ) u_timer (
      .clk_i    (clk),
      .reset_i  (reset),
      .clr_i    (accept || xfer),
      .en_i     (buf_busy && !accept),
      .expire_o (tmr_expire)
   );

   // Packing buffer and output word next-state
   always_comb begin
      buf_d    = buf_q;
      cnt_d    = cnt_q;
      wvalid_d = wvalid_q;
      wdata_d  = wdata_q;
      wcount_d = wcount_q;
      if (xfer) begin
         wvalid_d = 1'b1;
         wdata_d  = buf_q;
         wcount_d = cnt_q;
         buf_d    = '0;
         cnt_d    = '0;
         if (accept) begin
            buf_d[SYM_W-1:0] = sym;
            cnt_d            = CNT_W'(1);
         end else begin
            cnt_d = '0;
         end
      end else begin
         if (word_ready) begin
            wvalid_d = 1'b0;
         end else begin
            wvalid_d = wvalid_q;
         end
         if (accept) begin
            for (int k = 0; k < SLOTS; k++) begin
               if (cnt_q == CNT_W'(k)) begin
                  buf_d[k*SYM_W +: SYM_W] = sym;
               end else begin
                  buf_d[k*SYM_W +: SYM_W] = buf_q[k*SYM_W +: SYM_W];
               end
            end
            cnt_d = cnt_q + CNT_W'(1);
         end else begin
            cnt_d = cnt_q;
         end
      end
   end

   // Sequencer state: DRAIN completes once both the buffer and the output register are empty
   always_comb begin
      state_d = state_q;
      ended_d = ended_q;
      case (state_q)
         ST_FILL: begin
            if (test_ending) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_FILL;
            end
         end
         ST_DRAIN: begin
            if (!buf_busy && !wvalid_q) begin
               state_d = ST_ENDED;
               ended_d = 1'b1;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_ENDED: begin
            state_d = ST_ENDED;
            ended_d = 1'b1;
         end
         default: begin
            state_d = ST_FILL;
            ended_d = 1'b0;
         end
      endcase
   end

   // All state and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_FILL;
         buf_q    <= '0;
         cnt_q    <= '0;
         wvalid_q <= 1'b0;
         wdata_q  <= '0;
         wcount_q <= '0;
         ended_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         buf_q    <= buf_d;
         cnt_q    <= cnt_d;
         wvalid_q <= wvalid_d;
         wdata_q  <= wdata_d;
         wcount_q <= wcount_d;
         ended_q  <= ended_d;
      end
   end

   assign word_valid     = wvalid_q;
   assign word_data      = wdata_q;
   assign word_count     = wcount_q;
   assign dct_buffer     = buf_q;
   assign dct_count      = cnt_q;
   assign test_has_ended = ended_q;

endmodule

// File: tb/tb_soc_system_pcp_0_cpu_0_oci_dct_ctrl.sv
// Randomized scoreboard bench for the DCT buffer sequencer against a queue-based reference model.
module tb_soc_system_pcp_0_cpu_0_oci_dct_ctrl;

   localparam int T = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sym_valid = 1'b0;
   logic [1:0]  sym = 2'b00;
   logic        word_ready = 1'b0;
   logic        test_ending = 1'b0;
   logic        sym_ready;
   logic        word_valid;
   logic [29:0] word_data;
   logic [3:0]  word_count;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        test_has_ended;

   soc_system_pcp_0_cpu_0_oci_dct_ctrl #(
      .SYM_W         (2),
      .SLOTS         (15),
      .FLUSH_TIMEOUT (T)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .sym_valid      (sym_valid),
      .sym            (sym),
      .sym_ready      (sym_ready),
      .word_valid     (word_valid),
      .word_data      (word_data),
      .word_count     (word_count),
      .word_ready     (word_ready),
      .test_ending    (test_ending),
      .dct_buffer     (dct_buffer),
      .dct_count      (dct_count),
      .test_has_ended (test_has_ended)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [29:0] data;
      int          cnt;
   } word_t;

   int          n_chk = 0;
   int          n_fail = 0;
   word_t       exp_q[$];
   word_t       mon_e;
   logic [29:0] last_data = '0;
   int          last_cnt = 0;
   int          n_words = 0;

   // Reference model: symbols waiting in the word, one pending output word, idle cycles, phase
   logic [1:0]  m_buf[$];
   bit          m_ov = 1'b0;
   int          m_idle = 0;
   int          m_st = 0;      // 0 filling, 1 draining, 2 ended
   int          m_acc_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [29:0] pack();
      logic [29:0] w = '0;
      foreach (m_buf[i]) w[2*i +: 2] = m_buf[i];
      return w;
   endfunction

   task automatic model_reset();
      m_buf.delete();
      m_ov = 1'b0;
      m_idle = 0;
      m_st = 0;
      exp_q.delete();
   endtask

   task automatic model_step();
      int n = m_buf.size();
      bit free = !m_ov || word_ready;
      bit acc  = sym_valid && (m_st == 0) && (n < 15 || free);
      bit flush = free && (n > 0) && (n == 15 || m_st == 1 || (!acc && m_idle >= T - 1));
      int st_n = m_st;
      if (m_st == 0 && test_ending) st_n = 1;
      else if (m_st == 1 && n == 0 && !m_ov) st_n = 2;
      if (flush) begin
         exp_q.push_back('{pack(), n});
         m_buf.delete();
         m_ov = 1'b1;
      end else if (word_ready) begin
         m_ov = 1'b0;
      end
      if (acc) begin
         m_buf.push_back(sym);
         m_idle = 0;
         m_acc_total++;
      end else if (flush) begin
         m_idle = 0;
      end else if (n > 0) begin
         m_idle++;
      end
      m_st = st_n;
   endtask

   task automatic cycle(input logic sv, input logic [1:0] s, input logic wr, input logic te);
      sym_valid = sv;
      sym = s;
      word_ready = wr;
      test_ending = te;
      @(negedge clk);
      check("sym_ready", sym_ready, m_st == 0 && (m_buf.size() < 15 || !m_ov || wr));
      check("dct_count", dct_count, m_buf.size());
      check("dct_buffer", dct_buffer, pack());
      check("word_valid", word_valid, m_ov);
      check("test_has_ended", test_has_ended, m_st == 2);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sym_valid = 1'b0;
      word_ready = 1'b0;
      test_ending = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_sym_ready"}, sym_ready, 1);
      check({tag, "_word_valid"}, word_valid, 0);
      check({tag, "_word_data"}, word_data, 0);
      check({tag, "_word_count"}, word_count, 0);
      check({tag, "_dct_buffer"}, dct_buffer, 0);
      check({tag, "_dct_count"}, dct_count, 0);
      check({tag, "_test_has_ended"}, test_has_ended, 0);
   endtask

   // Monitor: every FIFO handshake pops the oldest expected word
   always @(negedge clk) begin
      if (!reset && word_valid && word_ready) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_word: got data 0x%0h count %0d, none expected", word_data, word_count);
         end else begin
            mon_e = exp_q.pop_front();
            check("word_data", word_data, mon_e.data);
            check("word_count", word_count, mon_e.cnt);
            last_data = word_data;
            last_cnt = word_count;
            n_words++;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got t=%0t, expected completion earlier", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      int guard;
      int nw;
      logic [1:0] s31;

      do_reset();
      check_reset("reset");

      // Full word of 2'b01 back to back
      for (int i = 0; i < 15; i++) cycle(1'b1, 2'b01, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 2'b00, 1'b1, 1'b0);
      check("full_word_data", last_data, 30'h15555555);
      check("full_word_count", last_cnt, 15);
      check("full_word_dct_count", dct_count, 0);

      // Partial word flushed by idle timeout
      for (int i = 0; i < 3; i++) cycle(1'b1, 2'b11, 1'b1, 1'b0);
      for (int i = 0; i < T + 4; i++) cycle(1'b0, 2'b00, 1'b1, 1'b0);
      check("timeout_word_data", last_data, 30'h3F);
      check("timeout_word_count", last_cnt, 3);

      // Backpressure: 30 accepted with the FIFO stalled, then release
      n0 = m_acc_total;
      guard = 0;
      while ((m_acc_total - n0) < 30 && guard < 100) begin
         cycle(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
         guard++;
      end
      check("bp_accepted", m_acc_total - n0, 30);
      check("bp_sym_ready", sym_ready, 0);
      check("bp_dct_count", dct_count, 15);
      check("bp_word_valid", word_valid, 1);
      s31 = 2'($urandom_range(0, 3));
      cycle(1'b1, s31, 1'b1, 1'b0);
      check("bp_release_count", dct_count, 1);
      check("bp_release_slot0", dct_buffer[1:0], s31);

      // Random traffic with idle bursts to hit timeouts under backpressure
      for (int blk = 0; blk < 4; blk++) begin
         for (int i = 0; i < 150; i++)
            cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, 1'b0);
         for (int i = 0; i < T + 6; i++)
            cycle(1'b0, 2'b00, $urandom_range(0, 1) != 0, 1'b0);
      end

      // Empty everything, then 7 symbols and an end-of-test drain
      guard = 0;
      while ((m_buf.size() != 0 || m_ov) && guard < 200) begin
         cycle(1'b0, 2'b00, 1'b1, 1'b0);
         guard++;
      end
      check("pre_drain_empty", m_buf.size() + int'(m_ov), 0);
      for (int i = 0; i < 7; i++) cycle(1'b1, 2'($urandom_range(0, 3)), 1'b1, 1'b0);
      cycle(1'b0, 2'b00, 1'b1, 1'b1);
      guard = 0;
      while (m_st != 2 && guard < 50) begin
         cycle(1'b1, 2'b10, 1'b1, 1'b0);
         guard++;
      end
      for (int i = 0; i < 5; i++) cycle(1'b1, 2'b01, 1'b1, 1'b1);
      check("drain_word_count", last_cnt, 7);
      check("drain_ended", test_has_ended, 1);
      check("drain_sym_ready", sym_ready, 0);
      check("drain_no_leftover", exp_q.size(), 0);

      // Reset mid-operation with a pending word and 9 buffered symbols
      do_reset();
      check_reset("reset2");
      for (int i = 0; i < 24; i++) cycle(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
      check("midop_dct_count", dct_count, 9);
      check("midop_word_valid", word_valid, 1);
      nw = n_words;
      do_reset();
      check_reset("reset3");
      for (int i = 0; i < 10; i++) cycle(1'b0, 2'b00, 1'b1, 1'b0);
      check("midop_no_word", n_words, nw);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/soc_system_pcp_0_cpu_0_oci_dct_ctrl.md
# soc_system_pcp_0_cpu_0_oci_dct_ctrl

Sequencer for the PCP CPU's debug compressed-trace (DCT) buffer. Packs 2-bit trace symbols from the OCI trace compressor into a 30-bit word (15 slots) and hands full or flushed words to the trace FIFO over a valid/ready handshake. Flushes a partial word on idle timeout, and runs the end-of-test drain. Sits between the OCI trace compressor and the trace FIFO. Exposes `dct_buffer`/`dct_count`/`test_has_ended` to the OCI test bench monitor.

## Interface
- `SYM_W`, 2, trace symbol width
- `SLOTS`, 15, symbols per word; word width `SYM_W*SLOTS` = 30
- `FLUSH_TIMEOUT`, 64, idle cycles before a partial word is flushed (≥2)

Ports:
- `clk`  in  1  single clock
- `reset`  in  1  synchronous, active-high
- `sym_valid`  in  1  trace symbol offered
- `sym`  in  2  trace symbol
- `sym_ready`  out  1  symbol accepted when `sym_valid & sym_ready` at a rising edge
- `word_valid`  out  1  packed word available to FIFO
- `word_data`  out  30  packed word, slot k at bits [2k+1:2k]
- `word_count`  out  4  valid slots in `word_data` (1..15)
- `word_ready`  in  1  FIFO accepts the word when `word_valid & word_ready`
- `test_ending`  in  1  level; request final drain
- `dct_buffer`  out  30  live packing buffer (unfilled slots 0)
- `dct_count`  out  4  live slot count, 0..15
- `test_has_ended`  out  1  sticky; drain complete

## Operation
- States: FILL (reset state), DRAIN, ENDED.
- `out_free = !word_valid | word_ready`.
- FILL: `sym_ready = (dct_count < 15) | out_free`. An accepted symbol is written to slot `dct_count`, and `dct_count` increments.
- Transfer: a word moves to the output register when `out_free` holds and one of these is true:
  - `dct_count == 15`,
  - the idle timer reaches `FLUSH_TIMEOUT-1`,
  - a drain is pending with `dct_count > 0`.
- On transfer:
  - `word_data` ← buffer, `word_count` ← `dct_count`, `word_valid` ← 1.
  - Buffer is cleared and `dct_count` ← 0.
  - If a symbol is accepted on the same edge, it lands in slot 0 and `dct_count` ← 1.
- `word_valid` clears on handshake unless a new transfer happens on the same edge.
- Idle timer:
  - Counts cycles with `dct_count > 0` and no symbol accepted.
  - Clears on accept or on transfer.
  - Width is `$clog2(FLUSH_TIMEOUT)`.
  - It never fires on a cycle in which a symbol is accepted.
- `test_ending` high in FILL moves to DRAIN next edge. A symbol accepted on that same edge is included in the drain.
- DRAIN:
  - `sym_ready = 0`.
  - Flush the partial word when `out_free`.
  - When `dct_count == 0` and `word_valid == 0`, go to ENDED.
- ENDED: `test_has_ended = 1` and `sym_ready = 0` until reset. `test_ending` is ignored after DRAIN is entered.
- Reset mid-operation discards buffer and output word (no flush).

## Timing
- Reset values: `sym_ready` 1 (FILL, empty), `word_valid` 0, `word_data` 0, `word_count` 0, `dct_buffer` 0, `dct_count` 0, `test_has_ended` 0, timer 0.
- All outputs are registered except `sym_ready`, which is combinational from state, `dct_count`, `word_valid` and `word_ready`.
- Full word: 15th symbol accepted at edge N; `dct_count == 15` during cycle N+1. With `out_free`, `word_valid` rises after edge N+1.
- Timeout: last accept at edge N; flush on edge N+FLUSH_TIMEOUT if `out_free`. Otherwise the flush is held until `out_free`.
- Drain with empty buffer and no pending word: `test_ending` at edge N, DRAIN after N; ENDED and `test_has_ended` after edge N+1.
- Backpressure: with `word_valid` stuck and the buffer full, `sym_ready` stays 0. No symbol is ever lost or overwritten.

## Structure
- Package `soc_system_pcp_0_cpu_0_oci_dct_pkg` holds:
  - `SYM_W` and `SLOTS` defaults,
  - word-width constant (30) and count width (4),
  - state enum {FILL, DRAIN, ENDED}.
- One sub-module, `soc_system_pcp_0_cpu_0_oci_dct_timer`: parameterised idle counter with clear/enable inputs and an expire output.

## Test plan
- Reset, then 15 symbols `2'b01` back-to-back with `word_ready = 1` → one word `0x15555555`, `word_count = 15`, `word_valid` one cycle; `dct_count` returns to 0.
- 3 symbols `2'b11` then idle, `FLUSH_TIMEOUT = 64` → flush at 64 cycles after last accept; `word_data = 0x3F`, `word_count = 3`.
- Hold `word_ready = 0`, push 31 symbols:
  - after 30 accepted, `sym_ready = 0` with `dct_count = 15` and `word_valid = 1`;
  - release `word_ready` → 31st accepted into slot 0 on the transfer edge, `dct_count = 1`.
- 7 symbols, then `test_ending` with `word_ready = 1` → partial word with `word_count = 7`; `test_has_ended` rises 1 cycle after the word handshake; `sym_ready` stays 0.
- Assert `reset` with `dct_count = 9` and `word_valid = 1` → next cycle all outputs at reset values; no word emitted.
